fetch_ctrl: RTL

- Instruction-fetch controller that sequences the combinational instruction memory (word-addressed by byte address >> 2, 32-bit read data, same-cycle read).
- Holds the fetch PC, drives the memory address and captures {pc, instr} pairs into a small prefetch FIFO.
- The FIFO feeds decode through a valid/ready handshake.
- Sits between imem and the decode stage; the execute stage redirects it on taken branches and jumps.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch controller.
// The optional FETCH_PERF_EN build adds performance counters in fetch_ctrl.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
// Head entry is read straight from storage so pushes are visible one edge later.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop && !empty && !flush;
  assign do_push_s = push && !flush && (!full || do_pop_s);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: fetch PC, IDLE/RUN/FAULT sequencing and prefetch FIFO.
// Defining FETCH_PERF_EN adds perf_fetch_cnt and perf_bubble_cnt outputs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IMEM_WORDS) << 2;

  function automatic logic in_range(input logic [XLEN-1:0] pc);
    return ({1'b0, pc} < PC_LIMIT);
  endfunction

  fetch_state_t    state_r;
  fetch_state_t    state_n_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] pc_n_s;
  logic            fault_r;
  logic            push_s;
  logic            pop_s;
  fetch_entry_t    wentry_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   count_s;
  logic            full_s;
  logic            empty_s;
  logic            unused_full_s;

  assign unused_full_s = full_s;
  assign pop_s    = out_ready && !empty_s;
  assign push_s   = (state_r == RUN) && fetch_en && !redirect_valid && in_range(fetch_pc_r)
                    && ((count_s < CW'(FIFO_DEPTH)) || pop_s);
  assign wentry_s = '{pc: fetch_pc_r, instr: imem_rd};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (wentry_s),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next fetch PC: a redirect overrides sequential advance.
  always_comb begin
    if (redirect_valid) begin
      pc_n_s = align_pc(redirect_pc);
    end else if (push_s) begin
      pc_n_s = fetch_pc_r + XLEN'(INSTR_BYTES);
    end else begin
      pc_n_s = fetch_pc_r;
    end
  end

  // Next state; the range check looks at the PC the next cycle will fetch from.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE, RUN: begin
        if (!fetch_en) begin
          state_n_s = IDLE;
        end else if (!in_range(pc_n_s)) begin
          state_n_s = FAULT;
        end else begin
          state_n_s = RUN;
        end
      end
      FAULT: begin
        if (redirect_valid && in_range(pc_n_s)) begin
          state_n_s = fetch_en ? RUN : IDLE;
        end else begin
          state_n_s = FAULT;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // FSM, fetch PC and the sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      fetch_pc_r <= pc_n_s;
      fault_r    <= (state_n_s == FAULT);
    end
  end

  assign imem_addr   = fetch_pc_r;
  assign fetch_fault = fault_r;
  assign out_valid   = !empty_s;
  assign out_pc      = empty_s ? 32'h0000_0000 : head_s.pc;
  assign out_instr   = empty_s ? NOP_INSTR : head_s.instr;

`ifdef FETCH_PERF_EN
  // Pushes and empty-while-running cycles, both wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (push_s) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if ((state_r == RUN) && empty_s) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
